// File: rtl/hweval_pkg.sv
// Shared types and step functions for the LFSR/MISR evaluation harness.
// Step functions work on a MaxW-wide container; only the low w bits are meaningful.
package hweval_pkg;

  localparam int unsigned MaxW = 256;

  localparam logic [63:0] DefLfsrPoly = 64'h1B;
  localparam logic [63:0] DefMisrPoly = 64'h1B;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } hweval_state_e;

  function automatic logic [MaxW-1:0] width_mask(input int unsigned w);
    return (w >= MaxW) ? '1 : ((MaxW'(1) << w) - MaxW'(1));
  endfunction

  // Left-shifting Galois step: the bit falling off the top folds back through poly.
  function automatic logic [MaxW-1:0] misr_step(input logic [MaxW-1:0] sig,
                                                input logic [MaxW-1:0] poly,
                                                input logic [MaxW-1:0] din,
                                                input int unsigned     w);
    logic [MaxW-1:0] nxt;
    logic            msb;
    msb = |(sig & (MaxW'(1) << (w - 1)));
    nxt = (sig << 1) & width_mask(w);
    if (msb) begin
      nxt = nxt ^ poly;
    end
    return (nxt ^ din) & width_mask(w);
  endfunction

  function automatic logic [MaxW-1:0] lfsr_step(input logic [MaxW-1:0] state,
                                                input logic [MaxW-1:0] poly,
                                                input int unsigned     w);
    return misr_step(state, poly, '0, w);
  endfunction

endpackage

// File: rtl/hweval_misr.sv
// Result compactor: MISR signature, saturating receive counter and sticky
// spurious-valid flag. A clear restarts all three for a new run.
module hweval_misr
  import hweval_pkg::*;
#(
  parameter int unsigned       MSG_W     = 64,
  parameter int unsigned       N_VEC     = 1024,
  parameter logic [MSG_W-1:0]  MISR_POLY = MSG_W'(DefMisrPoly),
  localparam int unsigned      CntW      = $clog2(N_VEC + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             window_i,
  input  logic             valid_i,
  input  logic [MSG_W-1:0] result_i,
  output logic [MSG_W-1:0] sig_o,
  output logic [CntW-1:0]  recv_cnt_o,
  output logic             complete_o,
  output logic             spurious_o
);

  logic [MSG_W-1:0] sig_q, sig_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             spurious_q, spurious_d;
  logic             full, accept;

  assign full   = (cnt_q == CntW'(N_VEC));
  assign accept = window_i & valid_i & ~full;

  always_comb begin
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    spurious_d = spurious_q;
    if (clear_i) begin
      sig_d      = '0;
      cnt_d      = '0;
      spurious_d = 1'b0;
    end else if (accept) begin
      sig_d = MSG_W'(misr_step(MaxW'(sig_q), MaxW'(MISR_POLY), MaxW'(result_i), MSG_W));
      cnt_d = cnt_q + CntW'(1);
    end else if (valid_i) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q      <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      spurious_q <= spurious_d;
    end
  end

  assign sig_o      = sig_q;
  assign recv_cnt_o = cnt_q;
  // Lets the FSM leave DRAIN on the same edge that absorbs the last result.
  assign complete_o = (cnt_d == CntW'(N_VEC));
  assign spurious_o = spurious_q;

endmodule

// File: rtl/hweval_lfsr_misr_harness.sv
// Self-running evaluation harness: LFSR vector source, run FSM and MISR result check.
// Defining HWEVAL_LATENCY_EN adds lat_first/lat_max latency tracking ports.
module hweval_lfsr_misr_harness
  import hweval_pkg::*;
#(
  parameter int unsigned      MSG_W     = 64,
  parameter int unsigned      KEY_W     = 768,
  parameter int unsigned      N_VEC     = 1024,
  parameter int unsigned      DRAIN_MAX = 64,
  parameter logic [MSG_W-1:0] LFSR_POLY = MSG_W'(DefLfsrPoly),
  parameter logic [MSG_W-1:0] LFSR_SEED = MSG_W'(64'h1),
  parameter logic [MSG_W-1:0] MISR_POLY = MSG_W'(DefMisrPoly),
  parameter logic [MSG_W-1:0] EXP_SIG   = '0,
  localparam int unsigned     CntW      = $clog2(N_VEC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             dut_start,
  output logic [MSG_W-1:0] dut_message,
  output logic [KEY_W-1:0] dut_round_keys,
  input  logic             dut_valid,
  input  logic [MSG_W-1:0] dut_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             err_spurious,
  output logic [MSG_W-1:0] signature,
`ifdef HWEVAL_LATENCY_EN
  output logic [CntW-1:0]  recv_cnt,
  output logic [15:0]      lat_first,
  output logic [15:0]      lat_max
`else
  output logic [CntW-1:0]  recv_cnt
`endif
);

  localparam int unsigned NSeg = KEY_W / MSG_W;
  localparam int unsigned TmrW = $clog2(DRAIN_MAX + 1);

  function automatic logic [MSG_W-1:0] rotl(input logic [MSG_W-1:0] v, input int unsigned r);
    logic [2*MSG_W-1:0] dbl;
    dbl = {v, v} << r;
    return dbl[2*MSG_W-1 -: MSG_W];
  endfunction

  hweval_state_e               state_q, state_d;
  logic [MSG_W-1:0]            lfsr_q, lfsr_d;
  logic [MSG_W-1:0]            msg_q, msg_d;
  logic [NSeg-1:0][MSG_W-1:0]  keys_q, keys_d, keys_vec;
  logic [CntW-1:0]             issue_cnt_q, issue_cnt_d;
  logic [TmrW-1:0]             timer_q, timer_d;
  logic                        start_q, start_d;
  logic                        timeout_q, timeout_d;
  logic [MSG_W-1:0]            vec;
  logic                        clear, issue, window, misr_complete;
  logic [MSG_W-1:0]            sig;
  logic [CntW-1:0]             recv;
  logic                        spurious;

  assign window = (state_q == StRun) || (state_q == StDrain);

  // A run's first vector comes straight from the seed, so a restart needs no reseed cycle.
  assign vec = (state_q == StRun) ? lfsr_q : LFSR_SEED;

  always_comb begin
    for (int unsigned i = 0; i < NSeg; i++) begin
      keys_vec[i] = rotl(vec, (i + 1) % MSG_W);
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    msg_d       = msg_q;
    keys_d      = keys_q;
    issue_cnt_d = issue_cnt_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    start_d     = 1'b0;
    clear       = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d     = StRun;
          clear       = 1'b1;
          issue       = 1'b1;
          issue_cnt_d = '0;
          timer_d     = '0;
          timeout_d   = 1'b0;
        end
      end
      StRun: begin
        if (issue_cnt_q == CntW'(N_VEC)) begin
          state_d = StDrain;
          timer_d = '0;
        end else begin
          issue = 1'b1;
        end
      end
      StDrain: begin
        timer_d = timer_q + TmrW'(1);
        if (misr_complete) begin
          state_d = StDone;
        end else if (timer_d == TmrW'(DRAIN_MAX)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      start_d     = 1'b1;
      msg_d       = vec;
      keys_d      = keys_vec;
      lfsr_d      = MSG_W'(lfsr_step(MaxW'(vec), MaxW'(LFSR_POLY), MSG_W));
      issue_cnt_d = issue_cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      msg_q       <= '0;
      keys_q      <= '0;
      issue_cnt_q <= '0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      msg_q       <= msg_d;
      keys_q      <= keys_d;
      issue_cnt_q <= issue_cnt_d;
      timer_q     <= timer_d;
      start_q     <= start_d;
      timeout_q   <= timeout_d;
    end
  end

  hweval_misr #(
    .MSG_W    (MSG_W),
    .N_VEC    (N_VEC),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (clear),
    .window_i  (window),
    .valid_i   (dut_valid),
    .result_i  (dut_result),
    .sig_o     (sig),
    .recv_cnt_o(recv),
    .complete_o(misr_complete),
    .spurious_o(spurious)
  );

  assign dut_start      = start_q;
  assign dut_message    = msg_q;
  assign dut_round_keys = KEY_W'(keys_q);
  assign busy           = window;
  assign done           = (state_q == StDone);
  assign timeout        = timeout_q;
  assign err_spurious   = spurious;
  assign signature      = sig;
  assign recv_cnt       = recv;
  assign pass           = done & ~timeout_q & (sig == EXP_SIG) & (recv == CntW'(N_VEC));

`ifdef HWEVAL_LATENCY_EN
  localparam int unsigned FifoAw = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam int unsigned FifoCw = $clog2(DRAIN_MAX + 1);

  logic [DRAIN_MAX-1:0][15:0] ts_q, ts_d;
  logic [FifoAw-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [FifoCw-1:0]          fcnt_q, fcnt_d;
  logic [15:0]                cyc_q, cyc_d, lat_first_q, lat_first_d, lat_max_q, lat_max_d;
  logic                       first_seen_q, first_seen_d;
  logic                       lat_accept, push, pop;
  logic [15:0]                head, lat;

  assign lat_accept = window & dut_valid & (recv != CntW'(N_VEC));
  // An empty FIFO with a same-cycle push means the result matches the vector just issued.
  assign head       = (fcnt_q == '0) ? cyc_q : ts_q[rd_q];
  assign lat        = cyc_q - head;

  always_comb begin
    ts_d         = ts_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    fcnt_d       = fcnt_q;
    cyc_d        = cyc_q;
    lat_first_d  = lat_first_q;
    lat_max_d    = lat_max_q;
    first_seen_d = first_seen_q;
    push         = 1'b0;
    pop          = 1'b0;
    if (clear) begin
      wr_d         = '0;
      rd_d         = '0;
      fcnt_d       = '0;
      cyc_d        = '0;
      lat_first_d  = '0;
      lat_max_d    = '0;
      first_seen_d = 1'b0;
    end else if (window) begin
      if (cyc_q != 16'hFFFF) begin
        cyc_d = cyc_q + 16'd1;
      end
      if (lat_accept) begin
        if (!first_seen_q) begin
          lat_first_d  = cyc_q;
          first_seen_d = 1'b1;
        end
        if (lat > lat_max_q) begin
          lat_max_d = lat;
        end
      end
      push = start_q && !(lat_accept && fcnt_q == '0);
      pop  = lat_accept && fcnt_q != '0;
      if (push && !pop && fcnt_q == FifoCw'(DRAIN_MAX)) begin
        push      = 1'b0;
        lat_max_d = 16'hFFFF;
      end
      if (push) begin
        ts_d[wr_q] = cyc_q;
        wr_d       = (wr_q == FifoAw'(DRAIN_MAX - 1)) ? '0 : wr_q + FifoAw'(1);
      end
      if (pop) begin
        rd_d = (rd_q == FifoAw'(DRAIN_MAX - 1)) ? '0 : rd_q + FifoAw'(1);
      end
      if (push && !pop) begin
        fcnt_d = fcnt_q + FifoCw'(1);
      end else if (pop && !push) begin
        fcnt_d = fcnt_q - FifoCw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      fcnt_q       <= '0;
      cyc_q        <= '0;
      lat_first_q  <= '0;
      lat_max_q    <= '0;
      first_seen_q <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      fcnt_q       <= fcnt_d;
      cyc_q        <= cyc_d;
      lat_first_q  <= lat_first_d;
      lat_max_q    <= lat_max_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign lat_first = lat_first_q;
  assign lat_max   = lat_max_q;
`else
  // Latency tracking not built: no extra state.
`endif

endmodule

// File: tb/tb_hweval_lfsr_misr_harness.sv
// Directed bench: loop-back stub DUT (1-cycle delay, optional invert/drop) around the harness,
// with hand-computed messages, timings and MISR signatures for N_VEC=4, seed 1, poly 0x1B.
module tb_hweval_lfsr_misr_harness;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic          dut_start;
  logic [63:0]   dut_message;
  logic [767:0]  dut_round_keys;
  logic          dut_valid;
  logic [63:0]   dut_result;
  logic          busy, done, pass, timeout, err_spurious;
  logic [63:0]   signature;
  logic [2:0]    recv_cnt;
`ifdef HWEVAL_LATENCY_EN
  logic [15:0]   lat_first, lat_max;
`endif

  logic          stub_valid;
  logic [63:0]   stub_result;
  int            stub_idx;
  logic          inj_valid;
  logic [63:0]   inj_result;
  logic          drop_mode, inv_mode;

  int            n_vec  = 0;
  int            n_miss = 0;
  int            starts, done_at;

  always #5 clk = ~clk;

  hweval_lfsr_misr_harness #(
    .MSG_W    (64),
    .KEY_W    (768),
    .N_VEC    (4),
    .DRAIN_MAX(8),
    .LFSR_SEED(64'h1),
    .EXP_SIG  (64'h72)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .dut_start     (dut_start),
    .dut_message   (dut_message),
    .dut_round_keys(dut_round_keys),
    .dut_valid     (dut_valid),
    .dut_result    (dut_result),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_spurious  (err_spurious),
    .signature     (signature),
`ifdef HWEVAL_LATENCY_EN
    .recv_cnt      (recv_cnt),
    .lat_first     (lat_first),
    .lat_max       (lat_max)
`else
    .recv_cnt      (recv_cnt)
`endif
  );

  // Loop-back stub: result follows start by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stub_valid  <= 1'b0;
      stub_result <= '0;
      stub_idx    <= 0;
    end else begin
      stub_valid  <= dut_start && !(drop_mode && stub_idx == 2);
      stub_result <= inv_mode ? ~dut_message : dut_message;
      if (!busy) stub_idx <= 0;
      else if (dut_start) stub_idx <= stub_idx + 1;
    end
  end

  assign dut_valid  = stub_valid | inj_valid;
  assign dut_result = inj_valid ? inj_result : stub_result;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse go, then watch up to 40 cycles; index 0 is the cycle after the go edge.
  task automatic run_once(input bit go_mid, output int n_start, output int t_done);
    n_start = 0;
    t_done  = -1;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut_start) begin
        if (n_start == 0) begin
          check_eq("key_seg0", dut_round_keys[63:0], 64'h2);
          check_eq("key_seg1", dut_round_keys[127:64], 64'h4);
          check_eq("key_seg11", dut_round_keys[767:704], 64'h1000);
        end
        if (n_start < 4) check_eq($sformatf("msg%0d", n_start), dut_message, 64'h1 << n_start);
        n_start++;
      end
      if (done) begin
        t_done = i;
        break;
      end
      go = go_mid && (i == 1);
    end
    go = 1'b0;
  endtask

  task automatic inject(input logic [63:0] val);
    @(negedge clk);
    inj_valid  = 1'b1;
    inj_result = val;
    @(negedge clk);
    inj_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    go         = 1'b0;
    inj_valid  = 1'b0;
    inj_result = '0;
    drop_mode  = 1'b0;
    inv_mode   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_start", 64'(dut_start), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_pass", 64'(pass), 64'd0);
    check_eq("rst_sig", signature, 64'd0);
    check_eq("rst_recv", 64'(recv_cnt), 64'd0);
    check_eq("rst_msg", dut_message, 64'd0);
    rst = 1'b0;

    // Spurious valid in IDLE
    inject(64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("idle_spur", 64'(err_spurious), 64'd1);
    check_eq("idle_sig", signature, 64'd0);
    check_eq("idle_recv", 64'(recv_cnt), 64'd0);

    // Plain loop-back: L = 1,2,4,8 cancels to a zero signature, which is not EXP_SIG
    run_once(1'b0, starts, done_at);
    check_eq("lb_starts", 64'(starts), 64'd4);
    check_eq("lb_done_at", 64'(done_at), 64'd5);
    check_eq("lb_recv", 64'(recv_cnt), 64'd4);
    check_eq("lb_sig", signature, 64'd0);
    check_eq("lb_pass", 64'(pass), 64'd0);
    check_eq("lb_spur_clr", 64'(err_spurious), 64'd0);
`ifdef HWEVAL_LATENCY_EN
    check_eq("lat_first", 64'(lat_first), 64'd1);
    check_eq("lat_max", 64'(lat_max), 64'd1);
`endif

    // Inverted loop-back restarted from DONE, go pulsed mid-run
    inv_mode = 1'b1;
    run_once(1'b1, starts, done_at);
    check_eq("inv_starts", 64'(starts), 64'd4);
    check_eq("inv_done_at", 64'(done_at), 64'd5);
    check_eq("inv_sig", signature, 64'h72);
    check_eq("inv_pass", 64'(pass), 64'd1);

    // Spurious valid in DONE leaves signature and count alone
    inject(64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("done_spur", 64'(err_spurious), 64'd1);
    check_eq("done_sig", signature, 64'h72);
    check_eq("done_recv", 64'(recv_cnt), 64'd4);

    // Third result dropped: DRAIN expires after 8 cycles
    drop_mode = 1'b1;
    run_once(1'b0, starts, done_at);
    check_eq("to_starts", 64'(starts), 64'd4);
    check_eq("to_done_at", 64'(done_at), 64'd12);
    check_eq("to_timeout", 64'(timeout), 64'd1);
    check_eq("to_pass", 64'(pass), 64'd0);
    check_eq("to_recv", 64'(recv_cnt), 64'd3);
    check_eq("to_sig", signature, 64'hFFFF_FFFF_FFFF_FFC3);
    check_eq("to_spur_clr", 64'(err_spurious), 64'd0);

    // Rerun clears timeout and reproduces the signature
    drop_mode = 1'b0;
    run_once(1'b0, starts, done_at);
    check_eq("re_sig", signature, 64'h72);
    check_eq("re_timeout", 64'(timeout), 64'd0);
    check_eq("re_pass", 64'(pass), 64'd1);

    // Reset mid-run
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    check_eq("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mr_start", 64'(dut_start), 64'd0);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_sig", signature, 64'd0);
    check_eq("mr_recv", 64'(recv_cnt), 64'd0);
    @(negedge clk);
    check_eq("mr_spur", 64'(err_spurious), 64'd0);
    check_eq("mr_idle_start", 64'(dut_start), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
